// File: rtl/id_ex_seg_reg.sv
// -----------------------------------------------------------------------------
// id_ex_seg_reg
//
// ID/EX pipeline segment register of the 5-stage CPU.
//
// This block captures the decoded operands and control bundle from ID and
// presents them to the EX-stage operand muxes and the ALU. It also handles
// the following:
//   * It detects load-use hazards against the instruction currently in EX.
//     When one is found it inserts exactly one bubble and raises stall_id,
//     so that the PC and IF/ID hold and re-present the dependent instruction.
//   * It squashes the ID->EX transfer on a flush (branch/jump redirect).
//     A flush takes priority even over a downstream stall.
//   * It holds every EX output while MEM stalls (stall_ext).
//   * It bypasses a same-cycle WB register write into the captured operand
//     data, so the regfile read-during-write gap is covered. x0 is never
//     bypassed.
//
// Edge priority: flush > stall_ext > load_use (bubble) > load.
//
// Optional feature, enabled by defining the macro ID_EX_PERF_EN:
//   It adds three saturating 32-bit event counters: perf_bubble_cnt,
//   perf_flush_cnt and perf_stall_cnt. Each counter counts the edges on
//   which its action is taken, using the same priority as above. When the
//   macro is undefined, these ports and counters do not exist.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous reset, active-high
//   flush        in   1       squash the ID->EX transfer
//   stall_ext    in   1       downstream stall, hold all EX outputs
//   id_valid     in   1       ID holds a real instruction
//   id_pc        in   XLEN    ID pc
//   id_inst      in   XLEN    ID instruction word
//   id_rs1/2     in   REG_AW  source register indices
//   id_rs1/2_used in  1       instruction reads rs1 / rs2
//   id_rd        in   REG_AW  destination index
//   id_rs1/2_data in  XLEN    regfile read data
//   id_imm       in   XLEN    sign-extended immediate
//   id_mem_read  in   1       instruction is a load
//   id_reg_we    in   1       instruction writes rd
//   id_ctrl      in   CTRL_W  opaque control bundle
//   wb_we        in   1       WB register write enable
//   wb_rd        in   REG_AW  WB destination
//   wb_data      in   XLEN    WB write data
//   ex_*         out  -       registered copies of the id_* fields
//   stall_id     out  1       combinational; hold PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module id_ex_seg_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_ext,

  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_inst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_mem_read,
  input  logic              id_reg_we,
  input  logic [CTRL_W-1:0] id_ctrl,

  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,

  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_inst,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_mem_read,
  output logic              ex_reg_we,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              stall_id
);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Returns the WB write data when WB is writing the register being read this
  // cycle. x0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic              we,
    input logic [REG_AW-1:0] wrd,
    input logic [XLEN-1:0]   wdata,
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rdata
  );
    if (we && (wrd != '0) && (wrd == rs)) return wdata;
    return rdata;
  endfunction

  // Increments by one but sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    if (cnt == 32'hFFFF_FFFF) return cnt;
    return cnt + 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Segment state
  // ---------------------------------------------------------------------------
  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   inst_q,     inst_d;
  logic [REG_AW-1:0] rs1_q,      rs1_d;
  logic [REG_AW-1:0] rs2_q,      rs2_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic              mem_read_q, mem_read_d;
  logic              reg_we_q,   reg_we_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;

  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              take_flush;
  logic              take_stall;
  logic              take_bubble;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;

  // ---------------------------------------------------------------------------
  // Hazard detection and action select (ID side, combinational)
  // ---------------------------------------------------------------------------

  // A load in EX has no data until MEM, so a dependent ID instruction must
  // wait one cycle. A load targeting x0 produces nothing to wait for.
  assign rs1_hit  = id_rs1_used && (id_rs1 == rd_q);
  assign rs2_hit  = id_rs2_used && (id_rs2 == rd_q);
  assign load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                    (rs1_hit || rs2_hit);

  // Only one of the following actions is taken on any edge.
  assign take_flush  = flush;
  assign take_stall  = !flush && stall_ext;
  assign take_bubble = !flush && !stall_ext && load_use;

  // A flush discards ID anyway, so it cancels the load-use hold. A downstream
  // stall must still freeze the front end, even during a flush.
  assign stall_id = stall_ext || (load_use && !flush);

  assign rs1_fwd = wb_bypass(wb_we, wb_rd, wb_data, id_rs1, id_rs1_data);
  assign rs2_fwd = wb_bypass(wb_we, wb_rd, wb_data, id_rs2, id_rs2_data);

  // ---------------------------------------------------------------------------
  // Next-state selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // Default is to hold, which is what stall_ext requires.
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    mem_read_d = mem_read_q;
    reg_we_d   = reg_we_q;
    ctrl_d     = ctrl_q;

    if (take_flush || take_bubble) begin
      // A bubble clears every field. This keeps the EX stage free of stale
      // values that would otherwise look like live operands.
      valid_d    = 1'b0;
      pc_d       = '0;
      inst_d     = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      mem_read_d = 1'b0;
      reg_we_d   = 1'b0;
      ctrl_d     = '0;
    end else if (!take_stall) begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      inst_d     = id_inst;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
      imm_d      = id_imm;
      mem_read_d = id_mem_read;
      reg_we_d   = id_reg_we;
      ctrl_d     = id_ctrl;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX boundary register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      mem_read_q <= 1'b0;
      reg_we_q   <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      mem_read_q <= mem_read_d;
      reg_we_q   <= reg_we_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_inst     = inst_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_mem_read = mem_read_q;
  assign ex_reg_we   = reg_we_q;
  assign ex_ctrl     = ctrl_q;

`ifdef ID_EX_PERF_EN
  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (take_bubble) bubble_cnt_d = sat_inc(bubble_cnt_q);
    if (take_flush)  flush_cnt_d  = sat_inc(flush_cnt_q);
    if (take_stall)  stall_cnt_d  = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_seg_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_seg_reg
//
// Self-checking bench for id_ex_seg_reg.
//
// It starts with a sequence of directed steps and then runs a randomized
// phase. On every cycle the EX outputs and stall_id are compared against a
// reference model of the EX-stage contents. The model is a single struct,
// and on each edge it is either replaced by the ID bundle, cleared to a
// bubble, or kept as it is.
// -----------------------------------------------------------------------------
module tb_id_ex_seg_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stall_ext;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_mem_read;
  logic        id_reg_we;
  logic [15:0] id_ctrl;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic        ex_mem_read;
  logic        ex_reg_we;
  logic [15:0] ex_ctrl;
  logic        stall_id;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  id_ex_seg_reg #(.XLEN(32), .REG_AW(5), .CTRL_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_ext(stall_ext),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_mem_read(id_mem_read), .id_reg_we(id_reg_we),
    .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_mem_read(ex_mem_read), .ex_reg_we(ex_reg_we), .ex_ctrl(ex_ctrl),
`ifdef ID_EX_PERF_EN
    .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .stall_id(stall_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the EX stage, as seen by the reference model.
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        mr;
    logic        we;
    logic [15:0] ctrl;
  } ex_t;

  ex_t         m;
  int          n_checks;
  int          n_passed;
  logic [31:0] m_bub, m_fl, m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("ex_valid",    {31'b0, ex_valid},    {31'b0, m.v});
    chk("ex_pc",       ex_pc,                m.pc);
    chk("ex_inst",     ex_inst,              m.inst);
    chk("ex_rs1",      {27'b0, ex_rs1},      {27'b0, m.rs1});
    chk("ex_rs2",      {27'b0, ex_rs2},      {27'b0, m.rs2});
    chk("ex_rd",       {27'b0, ex_rd},       {27'b0, m.rd});
    chk("ex_rs1_data", ex_rs1_data,          m.d1);
    chk("ex_rs2_data", ex_rs2_data,          m.d2);
    chk("ex_imm",      ex_imm,               m.imm);
    chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.mr});
    chk("ex_reg_we",   {31'b0, ex_reg_we},   {31'b0, m.we});
    chk("ex_ctrl",     {16'b0, ex_ctrl},     {16'b0, m.ctrl});
`ifdef ID_EX_PERF_EN
    chk("perf_bubble", perf_bubble_cnt, m_bub);
    chk("perf_flush",  perf_flush_cnt,  m_fl);
    chk("perf_stall",  perf_stall_cnt,  m_st);
`endif
  endtask

  function automatic logic [31:0] sat1(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 1;
  endfunction

  // Called just after a falling edge, with the ID inputs already driven.
  // It checks stall_id, steps the model across one rising edge and then
  // checks the registered outputs.
  task automatic tick();
    logic dep;
    ex_t  nxt;
    dep = m.v && m.mr && (m.rd != 0) && id_valid &&
          ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
    #1;
    chk("stall_id", {31'b0, stall_id}, {31'b0, stall_ext | (dep & ~flush)});
    if (flush) begin
      nxt = '0;
      m_fl = sat1(m_fl);
    end else if (stall_ext) begin
      nxt = m;
      m_st = sat1(m_st);
    end else if (dep) begin
      nxt = '0;
      m_bub = sat1(m_bub);
    end else begin
      nxt.v    = id_valid;
      nxt.pc   = id_pc;
      nxt.inst = id_inst;
      nxt.rs1  = id_rs1;
      nxt.rs2  = id_rs2;
      nxt.rd   = id_rd;
      nxt.d1   = (wb_we && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
      nxt.d2   = (wb_we && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
      nxt.imm  = id_imm;
      nxt.mr   = id_mem_read;
      nxt.we   = id_reg_we;
      nxt.ctrl = id_ctrl;
    end
    @(posedge clk);
    m = nxt;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; stall_ext = 0; id_valid = 0; id_pc = 0; id_inst = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_mem_read = 0;
    id_reg_we = 0; id_ctrl = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Present a load (lw) with destination rd on the ID side.
  task automatic present_lw(input logic [4:0] rd, input logic [31:0] pc);
    idle();
    id_valid = 1; id_pc = pc; id_inst = 32'h0000_2003 | {20'b0, rd, 7'b0};
    id_rd = rd; id_mem_read = 1; id_reg_we = 1; id_ctrl = 16'h0012;
  endtask

  // Present an add that reads rs1 and rs2 and writes rd.
  task automatic present_add(input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic [31:0] pc);
    idle();
    id_valid = 1; id_pc = pc; id_inst = 32'h0000_0033; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = u1; id_rs2_used = u2; id_rd = rd; id_reg_we = 1;
    id_rs1_data = 32'h1111_0000 + pc; id_rs2_data = 32'h2222_0000 + pc;
    id_ctrl = 16'h0001;
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    m = '0;
    m_bub = 0; m_fl = 0; m_st = 0;
    idle();
    rst = 1;
    #1;
    check_all();
    @(negedge clk);
    rst = 0;

    // 1: asynchronous reset clears the outputs before the next edge.
    present_add(5'd1, 1, 5'd2, 1, 5'd3, 32'h40);
    tick();
    chk("t1_pc_loaded", ex_pc, 32'h40);
    rst = 1;
    m = '0; m_bub = 0; m_fl = 0; m_st = 0;
    #1;
    chk("t1_rst_pc", ex_pc, 32'h0);
    check_all();
    #1 rst = 0;
    present_add(5'd1, 1, 5'd2, 1, 5'd3, 32'h44);
    tick();
    chk("t1_after_rst_pc", ex_pc, 32'h44);

    // 2: load-use inserts exactly one bubble.
    present_lw(5'd5, 32'h100);
    tick();
    present_add(5'd5, 1, 5'd6, 1, 5'd7, 32'h104);
    #1 chk("t2_stall_hi", {31'b0, stall_id}, 32'd1);
    tick();
    chk("t2_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("t2_stall_lo", {31'b0, stall_id}, 32'd0);
    tick();
    chk("t2_add_valid", {31'b0, ex_valid}, 32'd1);
    chk("t2_add_pc", ex_pc, 32'h104);

    // 3: no false stall for a load to x0 or an unused rs2.
    present_lw(5'd0, 32'h200);
    tick();
    present_add(5'd0, 1, 5'd0, 1, 5'd8, 32'h204);
    #1 chk("t3a_no_stall", {31'b0, stall_id}, 32'd0);
    tick();
    chk("t3a_loaded", ex_pc, 32'h204);
    present_lw(5'd5, 32'h210);
    tick();
    present_add(5'd1, 1, 5'd5, 0, 5'd9, 32'h214);
    #1 chk("t3b_no_stall", {31'b0, stall_id}, 32'd0);
    tick();
    chk("t3b_loaded", ex_pc, 32'h214);

    // 4: flush wins over stall_ext.
    present_add(5'd1, 1, 5'd2, 1, 5'd3, 32'h300);
    flush = 1; stall_ext = 1;
    tick();
    chk("t4_valid", {31'b0, ex_valid}, 32'd0);
    chk("t4_reg_we", {31'b0, ex_reg_we}, 32'd0);

    // 5: WB bypass, and x0 is never bypassed.
    idle();
    id_valid = 1; id_rs1 = 5'd7; id_rs1_used = 1; id_rs1_data = 32'h11;
    wb_we = 1; wb_rd = 5'd7; wb_data = 32'hAB;
    tick();
    chk("t5_bypass", ex_rs1_data, 32'hAB);
    wb_rd = 5'd0; id_rs1 = 5'd0;
    tick();
    chk("t5_x0", ex_rs1_data, 32'h11);

`ifdef ID_EX_PERF_EN
    // 6: event counters after 3 stalls, 1 flush and 2 bubbles.
    idle();
    rst = 1;
    m = '0; m_bub = 0; m_fl = 0; m_st = 0;
    #1 rst = 0;
    stall_ext = 1;
    repeat (3) tick();
    stall_ext = 0; flush = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      present_lw(5'd4, 32'h400);
      tick();
      present_add(5'd4, 1, 5'd0, 0, 5'd1, 32'h404);
      tick();
    end
    chk("t6_stall_cnt", perf_stall_cnt, 32'd3);
    chk("t6_flush_cnt", perf_flush_cnt, 32'd1);
    chk("t6_bubble_cnt", perf_bubble_cnt, 32'd2);
`endif

    // Randomized phase: small register range so hazards and bypasses are common.
    for (int i = 0; i < 400; i++) begin
      flush       = ($urandom_range(0, 9) == 0);
      stall_ext   = ($urandom_range(0, 7) == 0);
      id_valid    = ($urandom_range(0, 5) != 0);
      id_pc       = $urandom;
      id_inst     = $urandom;
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom);
      id_rs2_used = 1'($urandom);
      id_rd       = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_mem_read = ($urandom_range(0, 2) == 0);
      id_reg_we   = 1'($urandom);
      id_ctrl     = 16'($urandom);
      wb_we       = 1'($urandom);
      wb_rd       = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
